led_frame_scheduler: RTL
========================

# led_frame_scheduler

Sequences the serial LED-array writer (`writepixels`) from a 16-byte frame buffer: it issues one display-control command, waits a settle interval, then streams all 16 digit bytes.
- A new frame is scheduled on a periodic refresh tick, on any host write, on a control change, or on explicit request.
- It sits between the host side (UART decoder or test logic) and `writepixels`. It is the only source of that block's `valid`/`pos`/`value`.

## Interface
- `CLK_HZ`, 12_000_000: input clock rate.
- `REFRESH_HZ`, 1: periodic refresh rate. Tick period is `CLK_HZ/REFRESH_HZ` cycles.
- `SETTLE_CYCLES`, `CLK_HZ/1000`: idle gap between the control command and the first data byte.
- `BUSY_WAIT_MAX`, 4: number of cycles after `o_valid` within which `i_busy` must rise.
- `DEFAULT_BRIGHT`, 3'd1: brightness loaded at reset.

- `CLK`, input, 1: single clock.
- `RST`, input, 1: synchronous, active-high reset.
- `wr_en`, input, 1: frame-buffer write strobe.
- `wr_addr`, input, 4: digit index 0..15.
- `wr_data`, input, 8: segment byte.
- `ctrl_wr`, input, 1: load `ctrl_on` and `ctrl_bright`.
- `ctrl_on`, input, 1: display enable.
- `ctrl_bright`, input, 3: brightness 0..7.
- `refresh_req`, input, 1: request a frame.
- `i_busy`, input, 1: busy from `writepixels`.
- `o_valid`, output, 1: one-cycle command strobe to `writepixels`.
- `o_pos`, output, 8: 8'hFF for the control command, or 8'hC0+index for data.
- `o_value`, output, 8: command or data byte.
- `o_frame_done`, output, 1: one-cycle pulse when a frame completes.
- `o_active`, output, 1: high whenever the state is not IDLE.

## Operation
- **Storage:** 16x8 frame buffer plus a control register holding `on` and `bright`.
- **Writes:**
  - `wr_en` writes `buf[wr_addr]` in the same cycle, in any state.
  - `ctrl_wr` loads `on`/`bright` in the same cycle, in any state.
  - Both may occur in the same cycle; both take effect.
- **Control byte:** `8'h80 | (on<<3) | bright`. After reset it is 8'h89.
- **Pending flag:**
  - Set by `wr_en`, `ctrl_wr`, `refresh_req`, or the refresh tick.
  - Cleared on the cycle the FSM leaves IDLE.
  - A set event in the same cycle as the clear wins, so pending stays 1.
  - Events during a frame therefore cause exactly one follow-on frame.
- **Refresh tick:** counter runs 0..`CLK_HZ/REFRESH_HZ`-1 and wraps. The tick fires on the wrap cycle. The counter is free-running and never paused by the FSM.
- **FSM states:**
  - IDLE: if pending, go to CTRL.
  - CTRL: when `i_busy`=0, assert `o_valid`, drive `o_pos`=8'hFF and `o_value`=control byte, then go to WAIT(ret=SETTLE).
  - WAIT:
    - Waits for `i_busy` high, then low, then goes to ret.
    - If `i_busy` is not seen high within `BUSY_WAIT_MAX` cycles of `o_valid`, the command is treated as complete and the FSM goes to ret.
  - SETTLE: count `SETTLE_CYCLES` cycles, reset idx=0, then go to DATA.
  - DATA:
    - When `i_busy`=0, assert `o_valid` with `o_pos`=8'hC0+idx and `o_value`=`buf[idx]`, sampled at issue time.
    - Go to WAIT(ret=DATA); idx increments.
    - After idx=15 is issued and its WAIT completes, pulse `o_frame_done` and go to IDLE.
- **Data ordering:** a write to a byte already sent in the current frame appears in the next frame, because the write sets pending. A write to a byte not yet sent appears in the current frame.
- **Reset:**
  - Buffer is cleared to 8'h00; `on`=1; `bright`=`DEFAULT_BRIGHT`; pending=1; state is IDLE.
  - A first frame therefore starts immediately after reset.
  - Reset mid-frame aborts the frame with no `o_frame_done` pulse.

## Timing
- **Reset values:** `o_valid`=0, `o_pos`=8'h00, `o_value`=8'h00, `o_frame_done`=0, `o_active`=0.
- **Start latency:** IDLE with pending to `o_valid` of the control command is 2 cycles, given `i_busy`=0.
- **Strobe width:** `o_valid` is registered and high for exactly 1 cycle. It is never asserted while `i_busy`=1 or in the cycle after a prior `o_valid`.
- **Output hold:** `o_pos`/`o_value` are valid in the `o_valid` cycle and held until the next command.
- **Frame length:** 17 commands. Gaps are set by `i_busy` plus one cycle per transition. SETTLE adds exactly `SETTLE_CYCLES`.
- **Frame-done:** `o_frame_done` is high 1 cycle after the last `i_busy` fall; `o_active` drops the same cycle.

## Test plan
- **Reset and first frame.** Stimulus: RST 2 cycles, `writepixels` model busy for 10 cycles per command. Required response:
  - First command is pos=FF, value=89.
  - Then 16 commands with pos C0..CF, value 00.
  - One `o_frame_done` pulse.
- **Buffer write.**
  - Stimulus: write addr 3 = 8'h4F in IDLE.
  - Required response: one frame in which pos=C3 carries 4F and all other data bytes are 00.
- **Control change.**
  - Stimulus: `ctrl_wr` with on=0, bright=7.
  - Required response: the next control value is 87; pulse `ctrl_wr` again with on=1, bright=7 and the next control value is 8F.
- **Mid-frame write.** Stimulus: during the frame, write addr 0 = 8'h06 after pos C5 issues, and addr 10 = 8'hFB. Required response:
  - Current frame: C0=00, CA=FB.
  - Exactly one follow-on frame, with C0=06.
- **Busy handling.**
  - Stimulus: hold `i_busy`=1 for 50 cycles; separately, use a model that never raises busy.
  - Required response: no `o_valid` while busy=1; with the silent model, commands are spaced by `BUSY_WAIT_MAX`+2 cycles.
- **Periodic tick and reset abort.** Stimulus: `CLK_HZ`=1000, `REFRESH_HZ`=10, no host events; then assert RST during idx=7 of a frame. Required response:
  - One frame every 100 cycles.
  - The RST mid-frame gives `o_valid`=0 next cycle, no `o_frame_done`, then a fresh frame starting with FF/89.

Source files
------------

// File: rtl/led_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : led_frame_scheduler
// Purpose  : Drives the serial LED-array writer from a 16-byte frame buffer.
//            Each frame issues one display-control command (pos 8'hFF), waits
//            a settle interval, then streams the 16 digit bytes (pos 8'hC0+i).
//            Frames are scheduled by a periodic refresh tick, host buffer or
//            control writes, or an explicit request.
// Ports    : CLK, RST (sync, active-high)
//            wr_en/wr_addr/wr_data       - frame-buffer write
//            ctrl_wr/ctrl_on/ctrl_bright - control register load
//            refresh_req                 - request a frame
//            i_busy                      - busy from the writer
//            o_valid/o_pos/o_value       - command strobe and payload
//            o_frame_done                - one-cycle frame-complete pulse
//            o_active                    - high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================
module led_frame_scheduler #(
    parameter int         CLK_HZ         = 12_000_000,
    parameter int         REFRESH_HZ     = 1,
    parameter int         SETTLE_CYCLES  = CLK_HZ / 1000,
    parameter int         BUSY_WAIT_MAX  = 4,
    parameter logic [2:0] DEFAULT_BRIGHT = 3'd1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       ctrl_wr,
    input  logic       ctrl_on,
    input  logic [2:0] ctrl_bright,
    input  logic       refresh_req,
    input  logic       i_busy,
    output logic       o_valid,
    output logic [7:0] o_pos,
    output logic [7:0] o_value,
    output logic       o_frame_done,
    output logic       o_active
);

    localparam int TICK_PERIOD = (CLK_HZ / REFRESH_HZ > 0) ? (CLK_HZ / REFRESH_HZ) : 1;
    localparam int TICK_W      = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    // A zero settle still costs the single SETTLE cycle.
    localparam int SETTLE_LAST = (SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0;
    localparam int TMR_MAX     = (SETTLE_LAST > BUSY_WAIT_MAX) ? SETTLE_LAST : BUSY_WAIT_MAX;
    localparam int TMR_W       = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_PERIOD - 1);
    localparam logic [TMR_W-1:0]  SETTLE_END = TMR_W'(SETTLE_LAST);
    localparam logic [TMR_W-1:0]  WAIT_END   = TMR_W'(BUSY_WAIT_MAX);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CTRL   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DATA   = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [7:0]        frame_buf [16];
    logic              ctl_on;
    logic [2:0]        ctl_bright;
    logic [7:0]        ctrl_byte;

    logic              pending;
    logic              set_evt;
    logic              leave_idle;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    logic [TMR_W-1:0]  timer;
    logic              busy_seen;
    logic              ret_data;    // 0: WAIT returns to SETTLE, 1: to DATA
    logic [4:0]        idx;         // bit 4 set once all 16 bytes are issued

    logic              issue_ctrl;
    logic              issue_data;
    logic              idx_clr;
    logic              frame_end;
    logic              wait_done;

    assign ctrl_byte  = {4'b1000, ctl_on, ctl_bright};
    assign tick       = (tick_cnt == TICK_LAST);
    assign set_evt    = wr_en | ctrl_wr | refresh_req | tick;
    assign leave_idle = (state == ST_IDLE) && (state_next != ST_IDLE);
    assign o_active   = (state != ST_IDLE);

    // Once busy has been seen, wait for its fall; otherwise give up after
    // BUSY_WAIT_MAX cycles and treat the command as complete.
    assign wait_done  = busy_seen ? !i_busy : (!i_busy && (timer == WAIT_END));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        issue_ctrl = 1'b0;
        issue_data = 1'b0;
        idx_clr    = 1'b0;
        frame_end  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending) state_next = ST_CTRL;
            end
            ST_CTRL: begin
                if (!i_busy) begin
                    issue_ctrl = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_done) begin
                    if (!ret_data) begin
                        state_next = ST_SETTLE;
                    end else if (idx[4]) begin
                        state_next = ST_IDLE;
                        frame_end  = 1'b1;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_SETTLE: begin
                if (timer == SETTLE_END) begin
                    idx_clr    = 1'b1;
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!i_busy) begin
                    issue_data = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    // ------------------------------------------------------------------
    // Frame buffer and control register: writable in any state
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) frame_buf[i] <= 8'h00;
            ctl_on     <= 1'b1;
            ctl_bright <= DEFAULT_BRIGHT;
        end else begin
            if (wr_en) frame_buf[wr_addr] <= wr_data;
            if (ctrl_wr) begin
                ctl_on     <= ctrl_on;
                ctl_bright <= ctrl_bright;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scheduling, timers and command outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending      <= 1'b1;       // first frame starts right after reset
            tick_cnt     <= '0;
            timer        <= '0;
            busy_seen    <= 1'b0;
            ret_data     <= 1'b0;
            idx          <= '0;
            o_valid      <= 1'b0;
            o_pos        <= 8'h00;
            o_value      <= 8'h00;
            o_frame_done <= 1'b0;
        end else begin
            // A set event in the clearing cycle wins, so events arriving
            // during a frame yield exactly one follow-on frame.
            if (set_evt)         pending <= 1'b1;
            else if (leave_idle) pending <= 1'b0;

            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

            // Timer restarts on every state change; only SETTLE and WAIT look at it.
            if (state_next != state) timer <= '0;
            else                     timer <= timer + 1'b1;

            if (state != ST_WAIT) busy_seen <= 1'b0;
            else if (i_busy)      busy_seen <= 1'b1;

            if (idx_clr)         idx <= '0;
            else if (issue_data) idx <= idx + 1'b1;

            o_valid      <= issue_ctrl | issue_data;
            o_frame_done <= frame_end;

            if (issue_ctrl) begin
                ret_data <= 1'b0;
                o_pos    <= 8'hFF;
                o_value  <= ctrl_byte;
            end else if (issue_data) begin
                ret_data <= 1'b1;
                o_pos    <= {4'hC, idx[3:0]};
                o_value  <= frame_buf[idx[3:0]];
            end
        end
    end

endmodule
`default_nettype wire
